// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and sizing helpers for the nibble-serial add/subtract sequencer.
package serial_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int num_slices(input int width);
    return width / SLICE_W;
  endfunction

  // Slice index counter width; kept at least one bit so WIDTH=4 still has a register.
  function automatic int idx_width(input int width);
    int n;
    n = width / SLICE_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_add_sequencer_add4_slice.sv
// 4-bit ripple-carry adder made of gate-level full-adder cells; purely combinational.
module add4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[4];

endmodule

// File: rtl/serial_add_sequencer.sv
// Adds or subtracts two WIDTH-bit operands one nibble per clock through a single shared
// 4-bit slice. start_* and done_* are valid/ready pairs: a transfer happens on a rising edge
// where both valid and ready are high; valid never depends on ready.
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             sub,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int N  = num_slices(WIDTH);
  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_co;
  logic [IW-1:0]    r_idx;

  logic [WIDTH-1:0]   w_a_shift;
  logic [WIDTH-1:0]   w_b_shift;
  logic [SLICE_W-1:0] w_sum;
  logic               w_cout;
  logic               w_last;

  // Bring the current nibble down to bit 0 rather than using a multiplied part-select.
  assign w_a_shift = r_op_a >> {r_idx, 2'b00};
  assign w_b_shift = r_op_b >> {r_idx, 2'b00};
  assign w_last    = (r_idx == LAST_IDX);

  add4_slice u_slice (
    .a    (w_a_shift[SLICE_W-1:0]),
    .b    (w_b_shift[SLICE_W-1:0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    start_ready  = 1'b0;
    done_valid   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done_valid = 1'b1;
        if (done_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Subtraction is X + ~Y + 1, so the borrow-free indication falls out as the final carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_op_a  <= X;
            r_op_b  <= sub ? ~Y : Y;
            r_carry <= sub ? 1'b1 : Ci;
            r_idx   <= '0;
            r_s     <= '0;
          end
        end
        RUN: begin
          r_s[{r_idx, 2'b00} +: SLICE_W] <= w_sum;
          r_carry <= w_cout;
          if (w_last) begin
            r_co  <= w_cout;
            r_idx <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign S  = r_s;
  assign Co = r_co;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed and random checks of serial_add_sequencer against a plain-arithmetic model.
module tb_serial_add_sequencer;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             sub;
  logic             Ci;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .X           (X),
    .Y           (Y),
    .sub         (sub),
    .Ci          (Ci),
    .S           (S),
    .Co          (Co),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard: {Co, S}
  logic [WIDTH:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic s, input logic c);
    logic [WIDTH:0] r;
    if (s) begin
      r[WIDTH-1:0] = x - y;
      r[WIDTH]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    end
    return r;
  endfunction

  // driver: one full operation, optional stall before accepting the result
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic s, input logic c, input int stall);
    logic [WIDTH:0] e;
    int lat;
    check("idle_ready", start_ready, 1);
    exp_q.push_back(model(x, y, s, c));
    X = x; Y = y; sub = s; Ci = c;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    X = $urandom; Y = $urandom; sub = $urandom; Ci = $urandom;
    check("run_busy", busy, 1);
    check("run_not_ready", start_ready, 0);
    lat = 0;
    while (!done_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, N);
    e = exp_q.pop_front();
    check("result_s", S, e[WIDTH-1:0]);
    check("result_co", Co, e[WIDTH]);
    for (int k = 0; k < stall; k++) begin
      tick();
      check("stall_s", S, e[WIDTH-1:0]);
      check("stall_valid", done_valid, 1);
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check("back_idle_valid", done_valid, 0);
    check("back_idle_ready", start_ready, 1);
  endtask

  initial begin
    logic [WIDTH:0]   e;
    logic [WIDTH-1:0] bx, by;
    int cyc, prev, accepts, seen;
    bit acc, spurious;

    rst = 1'b1; start_valid = 1'b0; X = '0; Y = '0; sub = 1'b0; Ci = 1'b0; done_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_s", S, 0);
    check("rst_co", Co, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_start_ready", start_ready, 1);

    // directed
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'h00FF, 16'h0000, 1'b0, 1'b1, 0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b0, 0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 2);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0);

    // backpressure: result held while a competing start is offered
    exp_q.push_back(model(16'hABCD, 16'h1111, 1'b0, 1'b0));
    X = 16'hABCD; Y = 16'h1111; sub = 1'b0; Ci = 1'b0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    seen = 0;
    while (!done_valid && seen < 20) begin
      tick();
      seen++;
    end
    check("bp_latency", seen, N);
    e = exp_q.pop_front();
    bx = 16'h0F0F; by = 16'h7001;
    X = bx; Y = by; sub = 1'b1; Ci = 1'b0;
    start_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("bp_s", S, e[WIDTH-1:0]);
      check("bp_co", Co, e[WIDTH]);
      check("bp_start_ready", start_ready, 0);
      check("bp_done_valid", done_valid, 1);
      tick();
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check("bp_release_valid", done_valid, 0);
    check("bp_release_ready", start_ready, 1);
    exp_q.push_back(model(bx, by, 1'b1, 1'b0));
    tick();
    start_valid = 1'b0;
    seen = 0;
    while (!done_valid && seen < 20) begin
      tick();
      seen++;
    end
    check("bp_second_latency", seen, N);
    e = exp_q.pop_front();
    check("bp_second_s", S, e[WIDTH-1:0]);
    check("bp_second_co", Co, e[WIDTH]);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;

    // reset mid-operation on edge T+2
    X = 16'hFFFF; Y = 16'hFFFF; sub = 1'b0; Ci = 1'b1;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_s", S, 0);
    check("midrst_co", Co, 0);
    check("midrst_done_valid", done_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_start_ready", start_ready, 1);
    spurious = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done_valid) spurious = 1'b1;
      tick();
    end
    check("midrst_no_done", spurious, 0);

    // random single operations with random stalls
    for (int k = 0; k < 20; k++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3));

    // throughput: start and done_ready held high
    done_ready = 1'b1;
    start_valid = 1'b1;
    X = $urandom; Y = $urandom; sub = $urandom; Ci = $urandom;
    cyc = 0; prev = -1; accepts = 0;
    while ((accepts < 6 || exp_q.size() > 0) && cyc < 200) begin
      acc = 1'b0;
      if (done_valid) begin
        if (exp_q.size() == 0) begin
          check("tp_spurious_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("tp_s", S, e[WIDTH-1:0]);
          check("tp_co", Co, e[WIDTH]);
        end
      end
      if (start_ready && start_valid) begin
        exp_q.push_back(model(X, Y, sub, Ci));
        if (prev >= 0) check("tp_spacing", cyc - prev, N + 2);
        prev = cyc;
        accepts++;
        acc = 1'b1;
      end
      tick();
      cyc++;
      if (acc) begin
        X = $urandom; Y = $urandom; sub = $urandom; Ci = $urandom;
        if (accepts == 6) start_valid = 1'b0;
      end
    end
    check("tp_accepts", accepts, 6);
    check("tp_drained", exp_q.size(), 0);
    done_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Multi-cycle controller that adds or subtracts two WIDTH-bit operands using one shared 4-bit ripple-adder slice, processing one nibble per clock, LSB nibble first.
- A carry register links successive slices.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades throughput for area: one 4-bit adder instead of a full WIDTH-bit ripple chain.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4. Number of slices N = WIDTH/4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  operands X, Y, sub, Ci are valid
- start_ready  out  1  block can accept a new operation
- X  in  WIDTH  operand A
- Y  in  WIDTH  operand B
- sub  in  1  1 = X - Y, 0 = X + Y + Ci
- Ci  in  1  carry-in for add; ignored when sub=1
- S  out  WIDTH  result, registered
- Co  out  1  carry-out of MSB slice; for sub, 1 = no borrow (X >= Y unsigned)
- done_valid  out  1  S/Co hold a completed result
- done_ready  in  1  consumer accepts the result
- busy  out  1  high in RUN or DONE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, S=0, Co=0, carry=0, idx=0, done_valid=0, busy=0, start_ready=1 after the reset edge.
- Reset mid-operation: aborts at the next edge. No result is produced and the partial result is discarded (S cleared).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid && start_ready at edge T, latch opA=X and opB = sub ? ~Y : Y.
  - carry <= sub ? 1 : Ci; idx <= 0; S <= 0; go to RUN.
- RUN:
  - start_ready=0, busy=1.
  - Each edge: slice add of opA[4*idx+3:4*idx] + opB[4*idx+3:4*idx] + carry.
  - Write the 4-bit sum into S[4*idx+3:4*idx]; carry <= slice carry-out; idx <= idx+1.
  - On the edge processing idx=N-1: Co <= slice carry-out, go to DONE.
- Latency: slices are processed on edges T+1 .. T+N. done_valid is high from edge T+N onward (N=4 for WIDTH=16).
- DONE:
  - done_valid=1; S and Co stable.
  - On done_ready, go to IDLE at that edge; done_valid drops.
  - No bypass: a new start is accepted no earlier than the edge after the return to IDLE.
  - Minimum issue interval: N+2 cycles.
- Backpressure: DONE is held indefinitely while done_ready=0. S and Co do not change; start_valid is ignored.
- start_valid during RUN or DONE is ignored (start_ready=0). It is not queued.
- Changes on X, Y, sub or Ci after acceptance have no effect.
- S during RUN holds partial, undefined-for-use values; only S in DONE is meaningful.
- Arithmetic is modulo 2^WIDTH. There is no signed overflow flag.
- idx width is clog2(N), minimum 1; it never exceeds N-1.
- WIDTH=4 (N=1): RUN lasts exactly one edge.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE}
  - constant SLICE_W=4
  - function computing N and the idx width from WIDTH
- One sub-module, add4_slice:
  - 4-bit ripple adder built from full-adder cells (XOR/AND/OR gate form).
  - Ports: a[3:0], b[3:0], cin, sum[3:0], cout.
  - Purely combinational; instantiated once.
- The sequencer holds all registers and the FSM.

Test Plan:
- Carry ripple: WIDTH=16, X=0xFFFF, Y=0x0001, sub=0, Ci=0 -> done_valid 4 cycles after accept, S=0x0000, Co=1.
- Basic add with carry-in: X=0x1234, Y=0x4321, Ci=0 -> S=0x5555, Co=0. Then X=0x00FF, Y=0x0000, Ci=1 -> S=0x0100, Co=0.
- Subtract: X=0x0007, Y=0x0005, sub=1 -> S=0x0002, Co=1. Then X=0x0005, Y=0x0007, sub=1, Ci=1 -> S=0xFFFE, Co=0 (Ci ignored).
- Backpressure: hold done_ready=0 for 10 cycles after done -> S and Co stable, start_ready=0, and a start_valid pulse with new operands is not accepted. Release done_ready -> IDLE next edge, then the second op is accepted.
- Reset mid-op: assert rst on edge T+2 of an op -> after that edge state is IDLE, S=0, Co=0, done_valid=0, start_ready=1, and no done pulse ever appears.
- Throughput: back-to-back starts with done_ready tied 1 -> accepts are spaced exactly N+2=6 cycles apart, and every result is correct.
